frame_receiver: RTL and testbench
=================================

FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 The block SHALL have parameter START_STOPN, default 0, giving the start-bit level; the stop bit and idle level are ~START_STOPN.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstN  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port serialIn  input  1  serial line, one bit per clk cycle, no oversampling.
REQ-005 The block SHALL have port dataOut  output  7  last accepted data word.
REQ-006 The block SHALL have port valid  output  1  one-cycle pulse marking a newly accepted word on dataOut.
REQ-007 The block SHALL have port parityErr  output  1  parity status of the word on dataOut, updated with valid.
REQ-008 The block SHALL have port frameErr  output  1  one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port frameCount  output  8  count of accepted frames.

Function
REQ-010 Frame format SHALL be: start (START_STOPN), parity, data[0]..data[6] (LSB first), stop (~START_STOPN); 10 bits, one sample per cycle.
REQ-011 States SHALL be IDLE, PARITY, DATA, STOP.
REQ-012 The block SHALL set an armed flag after sampling serialIn == ~START_STOPN for at least one cycle while in IDLE or STOP.
REQ-013 In IDLE, a sample of START_STOPN SHALL move to PARITY only when armed; an unarmed start-level sample SHALL be ignored.
REQ-014 PARITY SHALL capture the parity bit and move to DATA with bit index 0.
REQ-015 DATA SHALL shift serialIn into bit [index] and increment the index, moving to STOP after index 6 is captured.
REQ-016 STOP SHALL always return to IDLE.
REQ-017 On a good stop level, the cycle after the stop sample SHALL have valid=1, dataOut=new word, and frameCount+1.
REQ-018 If the start bit is sampled on edge 0, valid SHALL be visible after edge 9 (10-cycle latency), high for exactly one cycle.
REQ-019 On a bad stop level, the cycle after the stop sample SHALL have frameErr=1 for one cycle, valid=0, and dataOut, parityErr and frameCount unchanged.
REQ-020 frameCount SHALL wrap from 255 to 0.
REQ-021 A good stop sample SHALL arm the block, so a start bit on the very next cycle SHALL be accepted (back-to-back frames).
REQ-022 dataOut and parityErr SHALL hold their values between valid pulses.

Reset
REQ-023 While rstN=0 at a clk edge, the block SHALL set state=IDLE, armed=0, index=0, dataOut=0, valid=0, parityErr=0, frameErr=0, frameCount=0.
REQ-024 A reset mid-frame SHALL discard the partial frame with no valid or frameErr pulse, and the block SHALL require re-arming before the next start.

Configuration
REQ-025 With macro FRAME_RECEIVER_PARITY_CHECK_EN defined, parityErr SHALL be set to (parity bit XOR ^data) at each valid, i.e. even parity across data+parity.
REQ-026 Without FRAME_RECEIVER_PARITY_CHECK_EN, parityErr SHALL be constant 0; the parity bit is still consumed and the frame timing is unchanged.

Structure
REQ-027 Package serial_link_pkg SHALL hold the state encodings, DATA_WIDTH=7 and FRAME_BITS=10, shared with the transmit side.
REQ-028 Sub-module rx_shift_reg SHALL implement the 7-bit indexed capture register with load enable and synchronous clear; all other logic SHALL be in frame_receiver.

Verification (START_STOPN=0, idle=1, macro defined unless stated)
REQ-029 The bench SHALL cover: idle 1 for 2 cycles, then 0,0,1,0,1,0,1,0,1,1 -> dataOut=0x55, valid pulse after the 10th edge, parityErr=0, frameCount=1.
REQ-030 The bench SHALL cover: frame for 0x03 with parity bit 1 -> valid with dataOut=0x03, parityErr=1; with the macro undefined -> parityErr=0.
REQ-031 The bench SHALL cover: 0x55 frame with stop bit 0 -> frameErr pulse, no valid, dataOut and frameCount unchanged.
REQ-032 The bench SHALL cover: line held 0 from reset release, then 0x55 frame -> no reception until a 1 is seen; the frame after arming is received correctly.
REQ-033 The bench SHALL cover: rstN low at DATA index 3, then released -> no pulses, outputs 0; the next full frame is received.
REQ-034 The bench SHALL cover: 256 back-to-back good frames -> frameCount 255 then 0, with a valid pulse for every frame.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared serial-link definitions: frame geometry and receiver state encoding,
// common to the transmit and receive sides.
package serial_link_pkg;

    localparam int DATA_WIDTH  = 7;
    localparam int FRAME_BITS  = 10;
    localparam int IDX_W       = 3;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARITY = 2'd1,
        DATA   = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Non-zero when parity bit plus data do not have even parity.
    function automatic logic parity_mismatch(input logic p, input logic [DATA_WIDTH-1:0] w);
        return p ^ (^w);
    endfunction

endpackage

// File: rtl/frame_receiver_if.sv
// Bundle of the receiver's serial input and result outputs; the master side
// drives the line, the slave side is the receiver.
interface frame_receiver_if;
    import serial_link_pkg::*;

    logic                   serialIn;
    logic [DATA_WIDTH-1:0]  dataOut;
    logic                   valid;
    logic                   parityErr;
    logic                   frameErr;
    logic [COUNT_W-1:0]     frameCount;

    modport master (
        output serialIn,
        input  dataOut, valid, parityErr, frameErr, frameCount
    );

    modport slave (
        input  serialIn,
        output dataOut, valid, parityErr, frameErr, frameCount
    );

endinterface

// File: rtl/rx_shift_reg.sv
// Indexed capture register: writes bit_i into word[idx_i] when load_i is set;
// clr_i (synchronous) takes priority and zeroes the word.
module rx_shift_reg
    import serial_link_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_d;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        assign word_d[gi] = clr_i ? 1'b0 :
                            ((load_i && (idx_i == IDX_W'(gi))) ? bit_i : word_q[gi]);
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign word_o = word_q;

endmodule

// File: rtl/frame_receiver.sv
// Serial frame receiver: start, parity, 7 data bits LSB first, stop; one sample per clk.
// Define FRAME_RECEIVER_PARITY_CHECK_EN to report even-parity errors on parityErr.
module frame_receiver
    import serial_link_pkg::*;
#(
    parameter logic START_STOPN = 1'b0
)(
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  serialIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  valid,
    output logic                  parityErr,
    output logic                  frameErr,
    output logic [COUNT_W-1:0]    frameCount
);

    localparam logic STOP_LVL = ~START_STOPN;

    rx_state_e             state_q, state_d;
    logic                  armed_q, armed_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [COUNT_W-1:0]    count_q, count_d;
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
    logic                  parity_q, parity_d;
`endif

    logic                  sr_clr;
    logic                  sr_load;
    logic [DATA_WIDTH-1:0] sr_word;

    rx_shift_reg u_shift (
        .clk    (clk),
        .clr_i  (sr_clr),
        .load_i (sr_load),
        .idx_i  (idx_q),
        .bit_i  (serialIn),
        .word_o (sr_word)
    );

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        count_d = count_q;
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
        parity_d = parity_q;
`endif
        sr_clr  = ~rstN;
        sr_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start level only counts once the line has been seen idle.
                if (serialIn == START_STOPN) begin
                    if (armed_q) begin
                        state_d = PARITY;
                        armed_d = 1'b0;
                        sr_clr  = 1'b1;
                    end
                end else begin
                    armed_d = 1'b1;
                end
            end
            PARITY: begin
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
                parity_d = serialIn;
`endif
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                sr_load = 1'b1;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = IDLE;
                if (serialIn == STOP_LVL) begin
                    armed_d = 1'b1;
                    valid_d = 1'b1;
                    data_d  = sr_word;
                    count_d = count_q + 1'b1;
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
                    perr_d  = parity_mismatch(parity_q, sr_word);
`else
                    perr_d  = 1'b0;
`endif
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            count_q <= '0;
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            count_q <= count_d;
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign dataOut    = data_q;
    assign valid      = valid_q;
    assign parityErr  = perr_q;
    assign frameErr   = ferr_q;
    assign frameCount = count_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Randomised bench for frame_receiver against a frame-level reference model,
// plus directed frames with hand-computed expectations.
module tb_frame_receiver;

    localparam logic START = 1'b0;
    localparam logic IDLEV = 1'b1;
`ifdef FRAME_RECEIVER_PARITY_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    frame_receiver_if bus();

    frame_receiver #(.START_STOPN(START)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .serialIn   (bus.serialIn),
        .dataOut    (bus.dataOut),
        .valid      (bus.valid),
        .parityErr  (bus.parityErr),
        .frameErr   (bus.frameErr),
        .frameCount (bus.frameCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects the 10 sampled bits of a frame, then judges it.
    logic       chk_en = 1'b0;
    logic       m_armed;
    logic       m_valid, m_ferr, m_perr;
    logic [6:0] m_data;
    logic [7:0] m_count;
    logic       bitq[$];

    always @(posedge clk) begin
        if (!rstN) begin
            chk_en  = 1'b1;
            m_armed = 1'b0;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_perr  = 1'b0;
            m_data  = '0;
            m_count = '0;
            bitq.delete();
        end else begin
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            if (bitq.size() > 0) begin
                bitq.push_back(bus.serialIn);
                if (bitq.size() == 10) begin
                    if (bitq[9] == IDLEV) begin
                        logic [6:0] w;
                        for (int i = 0; i < 7; i++) w[i] = bitq[2 + i];
                        m_valid = 1'b1;
                        m_data  = w;
                        m_perr  = PCHK & (bitq[1] ^ (^w));
                        m_count = m_count + 8'd1;
                        m_armed = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    bitq.delete();
                end
            end else if (bus.serialIn == START && m_armed) begin
                bitq.push_back(bus.serialIn);
                m_armed = 1'b0;
            end else if (bus.serialIn == IDLEV) begin
                m_armed = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_valid",      {31'd0, bus.valid},     {31'd0, m_valid});
            check("cmp_frameErr",   {31'd0, bus.frameErr},  {31'd0, m_ferr});
            check("cmp_dataOut",    {25'd0, bus.dataOut},   {25'd0, m_data});
            check("cmp_parityErr",  {31'd0, bus.parityErr}, {31'd0, m_perr});
            check("cmp_frameCount", {24'd0, bus.frameCount},{24'd0, m_count});
        end
    end

    // Log of frameCount at every valid pulse.
    logic [7:0] vlog[$];
    always @(negedge clk) begin
        if (bus.valid === 1'b1) vlog.push_back(bus.frameCount);
    end

    task automatic drive(input logic b);
        @(negedge clk);
        bus.serialIn = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(IDLEV);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic stop);
        drive(START);
        drive(p);
        for (int i = 0; i < 7; i++) drive(d[i]);
        drive(stop);
    endtask

    // Advance to the cycle after the stop sample, line idle.
    task automatic post();
        drive(IDLEV);
    endtask

    initial begin
        rstN         = 1'b0;
        bus.serialIn = IDLEV;
        repeat (3) @(negedge clk);
        check("rst_dataOut",    {25'd0, bus.dataOut},    32'h0);
        check("rst_valid",      {31'd0, bus.valid},      32'h0);
        check("rst_frameErr",   {31'd0, bus.frameErr},   32'h0);
        check("rst_parityErr",  {31'd0, bus.parityErr},  32'h0);
        check("rst_frameCount", {24'd0, bus.frameCount}, 32'h0);
        rstN = 1'b1;

        // 0x55, even parity, good stop
        idle(2);
        send_frame(7'h55, 1'b0, IDLEV);
        check("f55_no_early_valid", {31'd0, bus.valid}, 32'h0);
        post();
        check("f55_valid",      {31'd0, bus.valid},      32'h1);
        check("f55_dataOut",    {25'd0, bus.dataOut},    32'h55);
        check("f55_parityErr",  {31'd0, bus.parityErr},  32'h0);
        check("f55_frameCount", {24'd0, bus.frameCount}, 32'h1);
        @(negedge clk);
        check("f55_valid_one_cycle", {31'd0, bus.valid},   32'h0);
        check("f55_dataOut_hold",    {25'd0, bus.dataOut}, 32'h55);

        // 0x03 with parity bit 1
        idle(2);
        send_frame(7'h03, 1'b1, IDLEV);
        post();
        check("f03_valid",      {31'd0, bus.valid},      32'h1);
        check("f03_dataOut",    {25'd0, bus.dataOut},    32'h03);
        check("f03_parityErr",  {31'd0, bus.parityErr},  {31'd0, PCHK});
        check("f03_frameCount", {24'd0, bus.frameCount}, 32'h2);

        // bad stop bit
        idle(2);
        send_frame(7'h55, 1'b0, START);
        post();
        check("bad_frameErr",   {31'd0, bus.frameErr},   32'h1);
        check("bad_valid",      {31'd0, bus.valid},      32'h0);
        check("bad_dataOut",    {25'd0, bus.dataOut},    32'h03);
        check("bad_frameCount", {24'd0, bus.frameCount}, 32'h2);
        check("bad_parityErr",  {31'd0, bus.parityErr},  {31'd0, PCHK});
        @(negedge clk);
        check("bad_frameErr_one_cycle", {31'd0, bus.frameErr}, 32'h0);

        // line low from reset release: must not start until armed
        rstN = 1'b0;
        bus.serialIn = START;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (6) drive(START);
        check("unarmed_frameCount", {24'd0, bus.frameCount}, 32'h0);
        send_frame(7'h55, 1'b0, IDLEV);
        idle(12);
        send_frame(7'h55, 1'b0, IDLEV);
        post();
        check("rearm_valid",      {31'd0, bus.valid},      32'h1);
        check("rearm_dataOut",    {25'd0, bus.dataOut},    32'h55);
        check("rearm_frameCount", {24'd0, bus.frameCount}, 32'h2);

        // reset during DATA index 3
        idle(2);
        drive(START);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        @(negedge clk);
        rstN = 1'b0;
        bus.serialIn = 1'b1;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        bus.serialIn = START;
        repeat (3) @(negedge clk);
        check("midrst_dataOut",    {25'd0, bus.dataOut},    32'h0);
        check("midrst_valid",      {31'd0, bus.valid},      32'h0);
        check("midrst_frameErr",   {31'd0, bus.frameErr},   32'h0);
        check("midrst_frameCount", {24'd0, bus.frameCount}, 32'h0);
        idle(2);
        send_frame(7'h2A, 1'b1, IDLEV);
        post();
        check("midrst_next_valid",   {31'd0, bus.valid},      32'h1);
        check("midrst_next_dataOut", {25'd0, bus.dataOut},    32'h2A);
        check("midrst_next_perr",    {31'd0, bus.parityErr},  32'h0);
        check("midrst_next_count",   {24'd0, bus.frameCount}, 32'h1);

        // randomised traffic: gaps, junk bits, occasional bad stop
        for (int n = 0; n < 150; n++) begin
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                int len;
                len = $urandom_range(1, 12);
                for (int k = 0; k < len; k++) drive(1'($urandom));
            end else begin
                send_frame(7'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
            end
        end
        idle(12);

        // 256 back-to-back good frames from a fresh count
        @(negedge clk);
        rstN = 1'b0;
        bus.serialIn = IDLEV;
        vlog.delete();
        @(negedge clk);
        rstN = 1'b1;
        for (int n = 0; n < 256; n++) begin
            send_frame(7'($urandom), 1'($urandom), IDLEV);
        end
        post();
        check("b2b_frameCount_wrap", {24'd0, bus.frameCount}, 32'h0);
        @(negedge clk);
        check("b2b_valid_pulses", vlog.size(), 32'd256);
        if (vlog.size() == 256) begin
            check("b2b_count_255", {24'd0, vlog[254]}, 32'hFF);
            check("b2b_count_0",   {24'd0, vlog[255]}, 32'h0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
